// File: rtl/isqrt_pkg.sv
// Shared types and default sizing for the sequential integer square-root engine.
package isqrt_pkg;

  localparam int ISQRT_WIDTH       = 64;
  localparam int ISQRT_MULT_STAGES = 4;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    WAIT,
    CHECK,
    DONE
  } isqrt_state_t;

endpackage

// File: rtl/sqr_pipe_mult.sv
// Pipelined squarer: product = mcand * mplier, valid after STAGES cycles.
// Each pipeline register only loads behind a valid token, so the last stage holds until the next issue.
module sqr_pipe_mult #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  localparam int N     = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     mcand,
  input  logic [N-1:0]     mplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  prod_q [STAGES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= start;
      if (start) begin
        prod_q[0] <= WIDTH'(mcand) * WIDTH'(mplier);
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          prod_q[i] <= prod_q[i-1];
        end
      end
    end
  end

  assign done    = vld_q[STAGES-1];
  assign product = prod_q[STAGES-1];

endmodule

// File: rtl/isqrt_seq.sv
// Bit-by-bit integer square root: one trial bit per SET/WAIT/CHECK pass, MSB first.
// Latency is fixed at N*(MULT_STAGES+2) cycles from the accepting edge to the done pulse.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH       = ISQRT_WIDTH,
  parameter int MULT_STAGES = ISQRT_MULT_STAGES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] result,
  output logic [WIDTH/2:0]   remainder,
  output logic               exact
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  isqrt_state_t     state_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     root_q;
  logic [WIDTH-1:0] best_sq_q;
  logic [WIDTH-1:0] val_q;
  logic [N-1:0]     result_q;
  logic [N:0]       remainder_q;
  logic             exact_q;
  logic             done_q;
  logic             busy_q;
  logic             ready_q;

  logic             mult_start;
  logic             mult_done;
  logic [WIDTH-1:0] product;

  logic [N-1:0]     bit_d;
  logic [N-1:0]     trial_d;
  logic             too_big_d;
  logic [N-1:0]     root_d;
  logic [WIDTH-1:0] best_d;
  logic [N:0]       rem_d;

  // Remainder never exceeds 2*result, so the low N+1 bits of the difference are exact.
  always_comb begin
    bit_d      = N'(1) << idx_q;
    trial_d    = root_q | bit_d;
    mult_start = (state_q == SET);
    too_big_d  = (product > val_q);
    root_d     = too_big_d ? (root_q & ~bit_d) : root_q;
    best_d     = too_big_d ? best_sq_q : product;
    rem_d      = (N+1)'(val_q - best_d);
  end

  sqr_pipe_mult #(
    .WIDTH  (WIDTH),
    .STAGES (MULT_STAGES)
  ) u_sqr (
    .clock   (clock),
    .reset   (reset),
    .start   (mult_start),
    .mcand   (trial_d),
    .mplier  (trial_d),
    .done    (mult_done),
    .product (product)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      root_q      <= '0;
      best_sq_q   <= '0;
      val_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      exact_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            val_q     <= value;
            root_q    <= '0;
            best_sq_q <= '0;
            idx_q     <= IDX_W'(N - 1);
            state_q   <= SET;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        SET: begin
          root_q  <= trial_d;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mult_done) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          root_q    <= root_d;
          best_sq_q <= best_d;
          if (idx_q == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b1;
            result_q    <= root_d;
            remainder_q <= rem_d;
            exact_q     <= (rem_d == '0);
          end else begin
            idx_q   <= idx_q - IDX_W'(1);
            state_q <= SET;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign exact     = exact_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: default 64-bit instance and a WIDTH=16/MULT_STAGES=1 instance.
module tb_isqrt_seq;

  logic        clock;
  logic        reset;
  logic        s64, s16;
  logic [63:0] v64;
  logic [15:0] v16;
  logic        rdy64, bsy64, dn64, ex64;
  logic [31:0] res64;
  logic [32:0] rem64;
  logic        rdy16, bsy16, dn16, ex16;
  logic [7:0]  res16;
  logic [8:0]  rem16;

  int n_tests = 0;
  int n_fail  = 0;

  isqrt_seq dut64 (
    .clock(clock), .reset(reset), .start(s64), .value(v64),
    .ready(rdy64), .busy(bsy64), .done(dn64),
    .result(res64), .remainder(rem64), .exact(ex64)
  );

  isqrt_seq #(.WIDTH(16), .MULT_STAGES(1)) dut16 (
    .clock(clock), .reset(reset), .start(s16), .value(v16),
    .ready(rdy16), .busy(bsy16), .done(dn16),
    .result(res16), .remainder(rem16), .exact(ex16)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          sel;
    logic [63:0] v;
    logic [31:0] r;
    logic [32:0] rm;
    logic        ex;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Newton iteration on wide integers; independent of the trial-bit method.
  function automatic logic [31:0] ref_sqrt(input logic [63:0] v);
    logic [65:0] x, y, vv;
    if (v < 64'd2) return v[31:0];
    vv = {2'b00, v};
    x  = vv;
    y  = (x + vv / x) >> 1;
    while (y < x) begin
      x = y;
      y = (x + vv / x) >> 1;
    end
    return x[31:0];
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [63:0] v);
    if (sel) begin
      s16 = s;
      v16 = v[15:0];
    end else begin
      s64 = s;
      v64 = v;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is first seen.
  task automatic run(input bit sel, input logic [63:0] v, input int inj_at,
                     input logic [63:0] inj_v, output logic [31:0] r,
                     output logic [32:0] rm, output logic ex, output int cyc);
    logic d;
    drive(sel, 1'b1, v);
    cyc = 0;
    d   = 1'b0;
    while (!d && cyc < 1000) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (cyc == inj_at) drive(sel, 1'b1, inj_v);
      else               drive(sel, 1'b0, {$urandom, $urandom});
      d = sel ? dn16 : dn64;
      if (cyc == 1) chk("done_low_after_accept", {127'b0, d}, 128'd0);
      if (cyc == 10) begin
        chk("ready_low_while_busy", {127'b0, sel ? rdy16 : rdy64}, 128'd0);
        chk("busy_high_while_busy", {127'b0, sel ? bsy16 : bsy64}, 128'd1);
      end
    end
    r  = sel ? {24'b0, res16} : res64;
    rm = sel ? {24'b0, rem16} : rem64;
    ex = sel ? ex16 : ex64;
  endtask

  task automatic run_check(input string nm, input bit sel, input logic [63:0] v,
                           input int inj_at, input logic [63:0] inj_v,
                           input logic [31:0] er, input logic [32:0] erm, input logic eex);
    logic [31:0] r;
    logic [32:0] rm;
    logic        ex;
    int          cyc;
    run(sel, v, inj_at, inj_v, r, rm, ex, cyc);
    chk({nm, "_result"},    r,   er);
    chk({nm, "_remainder"}, rm,  erm);
    chk({nm, "_exact"},     ex,  eex);
    chk({nm, "_latency"},   cyc, sel ? 25 : 193);
  endtask

  task automatic run_model(input string nm, input bit sel, input logic [63:0] v);
    logic [31:0] er;
    logic [63:0] diff;
    er   = ref_sqrt(v);
    diff = v - {32'b0, er} * {32'b0, er};
    run_check(nm, sel, v, 0, 64'd0, er, diff[32:0], diff == 64'd0);
  endtask

  vec_t        tbl[12];
  logic [63:0] rv, t;
  int          pulses;

  initial begin
    tbl[0]  = '{1'b0, 64'd0,                  32'd0,          33'd0,            1'b1};
    tbl[1]  = '{1'b0, 64'd17,                 32'd4,          33'd1,            1'b0};
    tbl[2]  = '{1'b0, 64'd1000000,            32'd1000,       33'd0,            1'b1};
    tbl[3]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE,  1'b0};
    tbl[4]  = '{1'b0, 64'd1,                  32'd1,          33'd0,            1'b1};
    tbl[5]  = '{1'b0, 64'h4000_0000_0000_0000, 32'h8000_0000, 33'd0,            1'b1};
    tbl[6]  = '{1'b0, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 33'd0,            1'b1};
    tbl[7]  = '{1'b0, 64'hFFFF_FFFE_0000_0000, 32'hFFFF_FFFE, 33'h1_FFFF_FFFC,  1'b0};
    tbl[8]  = '{1'b1, 64'd40000,              32'd200,        33'd0,            1'b1};
    tbl[9]  = '{1'b1, 64'd65535,              32'd255,        33'd510,          1'b0};
    tbl[10] = '{1'b1, 64'd0,                  32'd0,          33'd0,            1'b1};
    tbl[11] = '{1'b1, 64'd3,                  32'd1,          33'd2,            1'b0};

    reset = 1'b1;
    s64 = 1'b0; s16 = 1'b0; v64 = '0; v16 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_state64", {rdy64, bsy64, dn64, ex64, res64, rem64}, {59'b0, 1'b1, 68'b0});
    chk("reset_state16", {rdy16, bsy16, dn16, ex16, res16, rem16}, {107'b0, 1'b1, 20'b0});

    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].v, 0, 64'd0,
                tbl[i].r, tbl[i].rm, tbl[i].ex);
      if (i % 2 == 1) repeat (2) @(negedge clock);
    end

    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        t  = {32'b0, $urandom};
        rv = t * t + 64'($urandom_range(0, 1));
      end else begin
        rv = {$urandom, $urandom} >> $urandom_range(0, 63);
      end
      run_model($sformatf("rand64_%0d", i), 1'b0, rv);
    end
    for (int i = 0; i < 8; i++) begin
      run_model($sformatf("rand16_%0d", i), 1'b1, 64'($urandom_range(0, 65535)));
    end

    // Start while busy is ignored; then start in the DONE cycle is accepted.
    repeat (2) @(negedge clock);
    run_check("midstart", 1'b0, 64'd1000000, 20, 64'd5, 32'd1000, 33'd0, 1'b1);
    run_check("backtoback", 1'b0, 64'd144, 0, 64'd0, 32'd12, 33'd0, 1'b1);

    // Reset mid-operation while a squarer token is in flight.
    repeat (2) @(negedge clock);
    drive(1'b0, 1'b1, 64'd1000000);
    @(posedge clock);
    @(negedge clock);
    drive(1'b0, 1'b0, 64'd0);
    repeat (49) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {rdy64, bsy64, dn64, ex64, res64, rem64}, {59'b0, 1'b1, 68'b0});
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    if (dn64) pulses++;
    chk("midreset_no_done", pulses, 0);
    run_check("after_reset", 1'b0, 64'd81, 0, 64'd0, 32'd9, 33'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
